// File: rtl/pong_pkg.sv
// Shared types and default tone/duration constants for the Pong sound-effect path.
// Also used by the game-logic block so both sides agree on timing.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HIT,
    WALL,
    SCORE_A,
    SCORE_B
  } sfx_state_t;

  localparam int TICK_DIV_DEF     = 100_000;
  localparam int HIT_HALF_DEF     = 113_636;
  localparam int WALL_HALF_DEF    = 227_273;
  localparam int SCORE_A_HALF_DEF = 56_818;
  localparam int SCORE_B_HALF_DEF = 113_636;
  localparam int HIT_TICKS_DEF    = 50;
  localparam int WALL_TICKS_DEF   = 30;
  localparam int SCORE_TICKS_DEF  = 150;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // The tone generator has no parameters, so its counter is sized for the longest default tone.
  localparam int HALF_W = $clog2(max2(max2(HIT_HALF_DEF, WALL_HALF_DEF),
                                      max2(SCORE_A_HALF_DEF, SCORE_B_HALF_DEF)));

endpackage

// File: rtl/pong_tone_gen.sv
// Square-wave generator: high for the first half-period after restart,
// then toggles every half-period. The half-period is a runtime input.
module pong_tone_gen
  import pong_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              restart_i,
  input  logic              run_i,
  input  logic [HALF_W-1:0] half_i,
  output logic              wave_o
);

  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic              wave_q, wave_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    cnt_d  = cnt_q;
    wave_d = wave_q;
    if (restart_i || !run_i) begin
      cnt_d  = '0;
      wave_d = 1'b1;
    end else if (cnt_q == half_i - HALF_W'(1)) begin
      cnt_d  = '0;
      wave_d = ~wave_q;
    end else begin
      cnt_d = cnt_q + HALF_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset_i) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wave_q <= wave_d;
    end
  end

  assign wave_o = wave_q;

endmodule

// File: rtl/pong_sfx.sv
// Pong sound effects: arbitrates game events into timed square-wave tones
// and gates the amplifier enable and audio level.
module pong_sfx
  import pong_pkg::*;
#(
  parameter int TICK_DIV     = TICK_DIV_DEF,
  parameter int HIT_HALF     = HIT_HALF_DEF,
  parameter int WALL_HALF    = WALL_HALF_DEF,
  parameter int SCORE_A_HALF = SCORE_A_HALF_DEF,
  parameter int SCORE_B_HALF = SCORE_B_HALF_DEF,
  parameter int HIT_TICKS    = HIT_TICKS_DEF,
  parameter int WALL_TICKS   = WALL_TICKS_DEF,
  parameter int SCORE_TICKS  = SCORE_TICKS_DEF
) (
  input  logic CLK100MHZ,
  input  logic reset,
  input  logic enable,
  input  logic mute,
  input  logic hit_pulse,
  input  logic wall_pulse,
  input  logic score_pulse,
  output logic AUD_PWM,
  output logic AUD_SD,
  output logic busy
);

  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam int DUR_W   = $clog2(max2(max2(HIT_TICKS, WALL_TICKS), SCORE_TICKS) + 1);

  sfx_state_t        state_q, state_d;
  logic              restart;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [HALF_W-1:0]  cur_half;
  logic [DUR_W-1:0]   cur_last;
  logic               tick, tone_end, wave;

  always_comb begin
    cur_half = '0;
    cur_last = '0;
    unique case (state_q)
      HIT:     begin cur_half = HALF_W'(HIT_HALF);     cur_last = DUR_W'(HIT_TICKS - 1);   end
      WALL:    begin cur_half = HALF_W'(WALL_HALF);    cur_last = DUR_W'(WALL_TICKS - 1);  end
      SCORE_A: begin cur_half = HALF_W'(SCORE_A_HALF); cur_last = DUR_W'(SCORE_TICKS - 1); end
      SCORE_B: begin cur_half = HALF_W'(SCORE_B_HALF); cur_last = DUR_W'(SCORE_TICKS - 1); end
      default: ;
    endcase
  end

  assign tick     = (presc_q == PRESC_W'(TICK_DIV - 1));
  assign tone_end = tick && (dur_q == cur_last) && (state_q != IDLE);

  always_ff @(posedge CLK100MHZ) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else if (score_pulse) begin
      state_d = SCORE_A;
      restart = 1'b1;
    end else if (hit_pulse && (state_q inside {IDLE, HIT, WALL})) begin
      state_d = HIT;
      restart = 1'b1;
    end else if (wall_pulse && (state_q inside {IDLE, WALL})) begin
      state_d = WALL;
      restart = 1'b1;
    end else if (tone_end) begin
      // The jingle chains into its second note; every other tone just stops.
      if (state_q == SCORE_A) begin
        state_d = SCORE_B;
        restart = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    presc_d = presc_q + PRESC_W'(1);
    dur_d   = dur_q;
    if (restart || state_d == IDLE) begin
      presc_d = '0;
      dur_d   = '0;
    end else if (tick) begin
      presc_d = '0;
      dur_d   = dur_q + DUR_W'(1);
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      presc_q <= '0;
      dur_q   <= '0;
    end else begin
      presc_q <= presc_d;
      dur_q   <= dur_d;
    end
  end

  pong_tone_gen u_tone (
    .clk_i     (CLK100MHZ),
    .reset_i   (reset),
    .restart_i (restart),
    .run_i     (state_d != IDLE),
    .half_i    (cur_half),
    .wave_o    (wave)
  );

  // Outputs decode registered state only; mute gates combinationally.
  always_comb begin
    busy    = (state_q != IDLE);
    AUD_SD  = busy && !mute;
    AUD_PWM = busy && !mute && wave;
  end

endmodule

// File: tb/tb_pong_sfx.sv
// Self-checking bench for pong_sfx: directed scenarios plus random events,
// compared each cycle against an effect/age model of the audible behaviour.
module tb_pong_sfx;

  localparam int TD = 4, HH = 3, WH = 5, SAH = 2, SBH = 4, HT = 3, WT = 2, ST = 2;
  localparam int M_IDLE = 0, M_HIT = 1, M_WALL = 2, M_SA = 3, M_SB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b1, mute = 1'b0;
  logic hit = 1'b0, wall = 1'b0, score = 1'b0;
  logic pwm, sd, busy;

  int checks = 0;
  int errors = 0;
  int m_fx = M_IDLE;
  int m_age = 0;

  pong_sfx #(
    .TICK_DIV(TD), .HIT_HALF(HH), .WALL_HALF(WH), .SCORE_A_HALF(SAH), .SCORE_B_HALF(SBH),
    .HIT_TICKS(HT), .WALL_TICKS(WT), .SCORE_TICKS(ST)
  ) dut (
    .CLK100MHZ   (clk),
    .reset       (reset),
    .enable      (enable),
    .mute        (mute),
    .hit_pulse   (hit),
    .wall_pulse  (wall),
    .score_pulse (score),
    .AUD_PWM     (pwm),
    .AUD_SD      (sd),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic int note_len(input int fx);
    case (fx)
      M_HIT:       return HT * TD;
      M_WALL:      return WT * TD;
      M_SA, M_SB:  return ST * TD;
      default:     return 0;
    endcase
  endfunction

  function automatic int note_half(input int fx);
    case (fx)
      M_HIT:   return HH;
      M_WALL:  return WH;
      M_SA:    return SAH;
      M_SB:    return SBH;
      default: return 1;
    endcase
  endfunction

  // Effect currently playing and how many cycles it has been playing.
  task automatic model_edge();
    if (reset || !enable) begin
      m_fx = M_IDLE; m_age = 0;
    end else if (score) begin
      m_fx = M_SA; m_age = 0;
    end else if (hit && (m_fx == M_IDLE || m_fx == M_HIT || m_fx == M_WALL)) begin
      m_fx = M_HIT; m_age = 0;
    end else if (wall && (m_fx == M_IDLE || m_fx == M_WALL)) begin
      m_fx = M_WALL; m_age = 0;
    end else if (m_fx != M_IDLE) begin
      m_age++;
      if (m_age == note_len(m_fx)) begin
        m_fx  = (m_fx == M_SA) ? M_SB : M_IDLE;
        m_age = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: apply held inputs at the edge, then compare outputs 1 time unit later.
  task automatic cycle();
    logic eb, es, ep;
    @(posedge clk);
    model_edge();
    #1;
    eb = (m_fx != M_IDLE);
    es = eb && !mute;
    ep = es && (((m_age / note_half(m_fx)) % 2) == 0);
    check("busy", busy, eb);
    check("aud_sd", sd, es);
    check("aud_pwm", pwm, ep);
    hit = 1'b0; wall = 1'b0; score = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    logic [11:0] hit_pat;
    logic [15:0] score_pat;
    int busy_cnt;
    int r;

    hit_pat   = 12'b111000111000;
    score_pat = 16'b1100110011110000;

    // Reset held with all pulses active.
    for (int i = 0; i < 3; i++) begin
      reset = 1'b1; hit = 1'b1; wall = 1'b1; score = 1'b1;
      cycle();
      check("reset_busy", busy, 1'b0);
      check("reset_pwm", pwm, 1'b0);
      check("reset_sd", sd, 1'b0);
    end
    reset = 1'b0;
    idle_cycles(2);

    // Single hit: 12 busy cycles with the 3-cycle half-period pattern.
    hit = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (busy) busy_cnt++;
      if (i < 12) check("hit_pattern", pwm, hit_pat[11 - i]);
      else        check("hit_silent", pwm, 1'b0);
    end
    check_int("hit_busy_len", busy_cnt, 12);

    // Score jingle; a wall pulse mid-jingle is ignored.
    score = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 18; i++) begin
      if (i == 5) wall = 1'b1;
      cycle();
      if (busy) busy_cnt++;
      if (i < 16) check("score_pattern", pwm, score_pat[15 - i]);
    end
    check_int("score_busy_len", busy_cnt, 16);

    // Wall and hit together: hit wins; a hit 5 cycles later restarts it.
    wall = 1'b1; hit = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 19; i++) begin
      if (i == 5) hit = 1'b1;
      cycle();
      if (busy) busy_cnt++;
      if (i == 5) check("restart_high", pwm, 1'b1);
    end
    check_int("restart_busy_len", busy_cnt, 17);

    // Muted hit: silent outputs, busy still runs for the full tone.
    mute = 1'b1; hit = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (busy) busy_cnt++;
    end
    check_int("mute_busy_len", busy_cnt, 12);
    mute = 1'b0;

    // Enable dropped mid-score, then a score pulse while disabled.
    score = 1'b1;
    idle_cycles(5);
    enable = 1'b0;
    cycle();
    check("disable_busy", busy, 1'b0);
    check("disable_pwm", pwm, 1'b0);
    score = 1'b1;
    cycle();
    check("disabled_score_ignored", busy, 1'b0);
    idle_cycles(2);
    enable = 1'b1;
    idle_cycles(2);

    // Random events, mute, enable and occasional reset against the model.
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 999));
      score = (r < 25);
      hit   = (r >= 25 && r < 90);
      wall  = (r >= 90 && r < 160);
      if ($urandom_range(0, 99) < 3) hit = 1'b1;
      if ($urandom_range(0, 99) < 3) wall = 1'b1;
      if ($urandom_range(0, 99) < 3) mute = ~mute;
      if ($urandom_range(0, 99) < 2) enable = ~enable;
      reset = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b0; enable = 1'b1; mute = 1'b0;
    idle_cycles(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
